// File: rtl/key_io_pkg.sv
// ---------------------------------------------------------------------------
// key_io_pkg
// Shared constants and types for the pushbutton I/O peripheral.
//   ADDR_KDATA / ADDR_KCTRL : register addresses in the data-memory map
//   NKEYS                   : default number of pushbuttons
//   READY_LSB / OVR_LSB     : bit offsets of the ready/ovr fields in KCTRL
// ---------------------------------------------------------------------------
package key_io_pkg;

   localparam logic [31:0] ADDR_KDATA = 32'hF000_0010;
   localparam logic [31:0] ADDR_KCTRL = 32'hF000_0110;
   localparam int          NKEYS      = 4;
   localparam int          READY_LSB  = 0;
   localparam int          OVR_LSB    = 8;

   // Which register the current bus address selects.
   typedef enum logic [1:0] {
      SEL_NONE  = 2'd0,
      SEL_KDATA = 2'd1,
      SEL_KCTRL = 2'd2
   } reg_sel_e;

endpackage

// File: rtl/key_debouncer.sv
// ---------------------------------------------------------------------------
// key_debouncer
// One pushbutton: 2-flop synchronizer, stability counter and debounced level.
//   clk_i          : system clock
//   rst_ni         : asynchronous active-low reset
//   key_ni         : raw key, active-low, asynchronous to clk_i
//   stb_o          : debounced level, 1 = pressed
//   press_pulse_o  : high for the single cycle whose closing edge raises stb_o
// ---------------------------------------------------------------------------
module key_debouncer #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic key_ni,
   output logic stb_o,
   output logic press_pulse_o
);

   localparam int             CW      = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic          s1_q, s2_q;
   logic          stb_q, stb_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Any cycle where the synchronized level agrees with stb restarts the
   // count, so only an uninterrupted run of DEBOUNCE_CYCLES flips stb.
   always_comb begin
      stb_d = stb_q;
      cnt_d = '0;
      if (~s2_q != stb_q) begin
         if (cnt_q == CNT_MAX) begin
            stb_d = ~stb_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_q  <= 1'b1;
         s2_q  <= 1'b1;
         stb_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         s1_q  <= key_ni;
         s2_q  <= s1_q;
         stb_q <= stb_d;
         cnt_q <= cnt_d;
      end
   end

   assign stb_o = stb_q;
   // Derived from next-state so the event flag updates on the same edge as stb.
   assign press_pulse_o = stb_d & ~stb_q;

endmodule

// File: rtl/key_input_device.sv
// ---------------------------------------------------------------------------
// key_input_device
// Memory-mapped pushbutton peripheral: debounces NKEYS active-low keys,
// exposes the debounced state (KDATA) and sticky press/overrun flags
// (KCTRL, write-1-to-clear) on the data-memory I/O read path.
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   key      : raw pushbuttons, active-low
//   abus     : MEM-stage address
//   wdata    : store data
//   we       : store strobe
//   rdata    : addressed register contents, 0 when not addressed
//   hit      : abus selects KDATA or KCTRL
//   pressed  : debounced key state, 1 = held
// ---------------------------------------------------------------------------
module key_input_device
   import key_io_pkg::*;
#(
   parameter int          DBITS           = 32,
   parameter int          NKEYS           = key_io_pkg::NKEYS,
   parameter int          DEBOUNCE_CYCLES = 500000,
   parameter logic [31:0] ADDR_KDATA      = key_io_pkg::ADDR_KDATA,
   parameter logic [31:0] ADDR_KCTRL      = key_io_pkg::ADDR_KCTRL
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [NKEYS-1:0] key,
   input  logic [DBITS-1:0] abus,
   input  logic [DBITS-1:0] wdata,
   input  logic             we,
   output logic [DBITS-1:0] rdata,
   output logic             hit,
   output logic [NKEYS-1:0] pressed
);

   logic [NKEYS-1:0] stb;
   logic [NKEYS-1:0] press;
   logic [NKEYS-1:0] ready_q, ready_d;
   logic [NKEYS-1:0] ovr_q, ovr_d;
   logic [NKEYS-1:0] clr_ready, clr_ovr;
   reg_sel_e         sel;

   for (genvar i = 0; i < NKEYS; i++) begin : g_key
      key_debouncer #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
         .clk_i        (clk),
         .rst_ni       (reset_n),
         .key_ni       (key[i]),
         .stb_o        (stb[i]),
         .press_pulse_o(press[i])
      );
   end

   always_comb begin
      if (abus == DBITS'(ADDR_KDATA)) begin
         sel = SEL_KDATA;
      end else if (abus == DBITS'(ADDR_KCTRL)) begin
         sel = SEL_KCTRL;
      end else begin
         sel = SEL_NONE;
      end
   end

   // A clear and a new press on the same key in one cycle leave ready set
   // and do not count as an overrun: the clear acknowledges the old event.
   always_comb begin
      clr_ready = '0;
      clr_ovr   = '0;
      if (we && sel == SEL_KCTRL) begin
         clr_ready = wdata[READY_LSB +: NKEYS];
         clr_ovr   = wdata[OVR_LSB +: NKEYS];
      end
      ready_d = (ready_q & ~clr_ready) | press;
      ovr_d   = (ovr_q & ~clr_ovr) | (press & ready_q & ~clr_ready);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ready_q <= '0;
         ovr_q   <= '0;
      end else begin
         ready_q <= ready_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      rdata = '0;
      hit   = 1'b0;
      case (sel)
         SEL_KDATA: begin
            hit              = 1'b1;
            rdata[NKEYS-1:0] = stb;
         end
         SEL_KCTRL: begin
            hit                      = 1'b1;
            rdata[READY_LSB +: NKEYS] = ready_q;
            rdata[OVR_LSB +: NKEYS]   = ovr_q;
         end
         default: ;
      endcase
   end

   assign pressed = stb;

   // Remaining store-data bits have no register behind them.
   logic unused_wdata;
   assign unused_wdata = ^wdata;

endmodule

// File: tb/tb_key_input_device.sv
module tb_key_input_device;

   localparam logic [31:0] KDATA = 32'hF000_0010;
   localparam logic [31:0] KCTRL = 32'hF000_0110;
   localparam logic [31:0] KBAD  = 32'hF000_0014;

   logic        clk;
   logic        reset_n;
   logic [3:0]  key;
   logic [31:0] abus;
   logic [31:0] wdata;
   logic        we;
   logic [31:0] rdata;
   logic        hit;
   logic [3:0]  pressed;

   int pass_cnt = 0;
   int total    = 0;

   key_input_device #(
      .DBITS(32),
      .NKEYS(4),
      .DEBOUNCE_CYCLES(4),
      .ADDR_KDATA(KDATA),
      .ADDR_KCTRL(KCTRL)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .key    (key),
      .abus   (abus),
      .wdata  (wdata),
      .we     (we),
      .rdata  (rdata),
      .hit    (hit),
      .pressed(pressed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic write_kctrl(input logic [31:0] v);
      abus  = KCTRL;
      wdata = v;
      we    = 1'b1;
      tick();
      we    = 1'b0;
      wdata = '0;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      key     = 4'b1111;
      abus    = KCTRL;
      wdata   = '0;
      we      = 1'b0;
      tick(3);
      total++;
      if (pressed !== 4'b0000) $display("FAIL reset_pressed: got %b expected %b", pressed, 4'b0000);
      else pass_cnt++;
      reset_n = 1'b1;
      tick(6);
      total++;
      if (pressed !== 4'b0000) $display("FAIL post_reset_pressed: got %b expected %b", pressed, 4'b0000);
      else pass_cnt++;
      total++;
      if (rdata !== 32'h0) $display("FAIL reset_kctrl: got %h expected %h", rdata, 32'h0);
      else pass_cnt++;
      total++;
      if (hit !== 1'b1) $display("FAIL reset_hit: got %b expected %b", hit, 1'b1);
      else pass_cnt++;
   endtask

   task automatic test_clean_press;
      abus   = KCTRL;
      key[2] = 1'b0;          // set up before edge E
      tick(4);                // just after E+3
      total++;
      if (pressed !== 4'b0000) $display("FAIL press_early: got %b expected %b", pressed, 4'b0000);
      else pass_cnt++;
      tick();                 // E+4
      total++;
      if (pressed !== 4'b0000) $display("FAIL press_e4: got %b expected %b", pressed, 4'b0000);
      else pass_cnt++;
      tick();                 // E+5
      total++;
      if (pressed !== 4'b0100) $display("FAIL press_e5: got %b expected %b", pressed, 4'b0100);
      else pass_cnt++;
      total++;
      if (rdata !== 32'h4) $display("FAIL press_kctrl: got %h expected %h", rdata, 32'h4);
      else pass_cnt++;
      key[2] = 1'b1;
      tick(7);
      total++;
      if (pressed !== 4'b0000) $display("FAIL release_pressed: got %b expected %b", pressed, 4'b0000);
      else pass_cnt++;
      total++;
      if (rdata !== 32'h4) $display("FAIL release_kctrl: got %h expected %h", rdata, 32'h4);
      else pass_cnt++;
      write_kctrl(32'h4);
      total++;
      if (rdata !== 32'h0) $display("FAIL clear_kctrl: got %h expected %h", rdata, 32'h0);
      else pass_cnt++;
   endtask

   task automatic test_glitch;
      int bad;
      bad    = 0;
      abus   = KCTRL;
      key[0] = 1'b0;
      for (int c = 0; c < 12; c++) begin
         if (c == 3) key[0] = 1'b1;
         tick();
         if (pressed !== 4'b0000 || rdata !== 32'h0) bad++;
      end
      total++;
      if (bad != 0) $display("FAIL glitch: got %0d bad cycles (pressed=%b kctrl=%h) expected 0", bad, pressed, rdata);
      else pass_cnt++;
   endtask

   task automatic test_overrun;
      abus = KCTRL;
      for (int r = 0; r < 2; r++) begin
         key[1] = 1'b0;
         tick(7);
         key[1] = 1'b1;
         tick(7);
      end
      total++;
      if (rdata !== 32'h202) $display("FAIL ovr_set: got %h expected %h", rdata, 32'h202);
      else pass_cnt++;
      write_kctrl(32'h200);
      total++;
      if (rdata !== 32'h2) $display("FAIL ovr_clear: got %h expected %h", rdata, 32'h2);
      else pass_cnt++;
      write_kctrl(32'h2);
      total++;
      if (rdata !== 32'h0) $display("FAIL ready_clear: got %h expected %h", rdata, 32'h0);
      else pass_cnt++;
   endtask

   task automatic test_clear_and_press;
      abus   = KCTRL;
      key[0] = 1'b0;
      tick(7);
      key[0] = 1'b1;
      tick(7);
      total++;
      if (rdata !== 32'h1) $display("FAIL cp_setup: got %h expected %h", rdata, 32'h1);
      else pass_cnt++;
      key[0] = 1'b0;          // before edge E
      tick(5);                // just after E+4
      total++;
      if (pressed !== 4'b0000) $display("FAIL cp_align: got %b expected %b", pressed, 4'b0000);
      else pass_cnt++;
      write_kctrl(32'h1);     // sampled at E+5, same edge stb rises
      total++;
      if (pressed !== 4'b0001) $display("FAIL cp_pressed: got %b expected %b", pressed, 4'b0001);
      else pass_cnt++;
      total++;
      if (rdata !== 32'h1) $display("FAIL cp_kctrl: got %h expected %h", rdata, 32'h1);
      else pass_cnt++;
      key[0] = 1'b1;
      tick(7);
      write_kctrl(32'h1);
      total++;
      if (rdata !== 32'h0) $display("FAIL cp_cleanup: got %h expected %h", rdata, 32'h0);
      else pass_cnt++;
   endtask

   task automatic test_decode;
      key[3] = 1'b0;
      tick(7);
      abus = KDATA;
      #1;
      total++;
      if (rdata !== 32'h8) $display("FAIL kdata_read: got %h expected %h", rdata, 32'h8);
      else pass_cnt++;
      total++;
      if (hit !== 1'b1) $display("FAIL kdata_hit: got %b expected %b", hit, 1'b1);
      else pass_cnt++;
      abus = KBAD;
      #1;
      total++;
      if (hit !== 1'b0) $display("FAIL bad_hit: got %b expected %b", hit, 1'b0);
      else pass_cnt++;
      total++;
      if (rdata !== 32'h0) $display("FAIL bad_rdata: got %h expected %h", rdata, 32'h0);
      else pass_cnt++;
      // All-ones store to KDATA and to an unmapped address must not clear ready[3].
      abus  = KDATA;
      wdata = 32'hFFFF_FFFF;
      we    = 1'b1;
      tick();
      abus  = KBAD;
      tick();
      we    = 1'b0;
      wdata = '0;
      abus  = KDATA;
      #1;
      total++;
      if (rdata !== 32'h8) $display("FAIL kdata_after_write: got %h expected %h", rdata, 32'h8);
      else pass_cnt++;
      abus = KCTRL;
      #1;
      total++;
      if (rdata !== 32'h8) $display("FAIL kctrl_after_kdata_write: got %h expected %h", rdata, 32'h8);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_count;
      abus   = KCTRL;
      key[1] = 1'b0;
      tick(3);
      reset_n = 1'b0;
      #1;
      total++;
      if (rdata !== 32'h0) $display("FAIL midreset_kctrl: got %h expected %h", rdata, 32'h0);
      else pass_cnt++;
      total++;
      if (pressed !== 4'b0000) $display("FAIL midreset_pressed: got %b expected %b", pressed, 4'b0000);
      else pass_cnt++;
      key = 4'b1111;
      tick(2);
      reset_n = 1'b1;
      tick(8);
      total++;
      if (rdata !== 32'h0 || pressed !== 4'b0000)
         $display("FAIL after_midreset: got kctrl=%h pressed=%b expected 0", rdata, pressed);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_glitch();
      test_overrun();
      test_clear_and_press();
      test_decode();
      test_reset_mid_count();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
